// File: rtl/ps2_disp_pkg.sv
// Shared scan codes, segment ROM and receiver state encoding for the
// PS/2 keypad-to-7-segment display path.
package ps2_disp_pkg;

   localparam logic [7:0] SC_D0   = 8'h45;
   localparam logic [7:0] SC_D1   = 8'h16;
   localparam logic [7:0] SC_D2   = 8'h1E;
   localparam logic [7:0] SC_D3   = 8'h26;
   localparam logic [7:0] SC_D4   = 8'h25;
   localparam logic [7:0] SC_D5   = 8'h2E;
   localparam logic [7:0] SC_D6   = 8'h36;
   localparam logic [7:0] SC_D7   = 8'h3D;
   localparam logic [7:0] SC_D8   = 8'h3E;
   localparam logic [7:0] SC_D9   = 8'h46;
   localparam logic [7:0] SC_BKSP = 8'h66;
   localparam logic [7:0] SC_EXT  = 8'hE0;
   localparam logic [7:0] SC_BRK  = 8'hF0;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

   typedef struct packed {
      logic       hit;
      logic [3:0] val;
   } key_digit_t;

   // {g,f,e,d,c,b,a}, active-low
   function automatic logic [6:0] seg_rom(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   function automatic key_digit_t decode_digit(input logic [7:0] code);
      key_digit_t r;
      r.hit = 1'b1;
      r.val = 4'd0;
      case (code)
         SC_D0:   r.val = 4'd0;
         SC_D1:   r.val = 4'd1;
         SC_D2:   r.val = 4'd2;
         SC_D3:   r.val = 4'd3;
         SC_D4:   r.val = 4'd4;
         SC_D5:   r.val = 4'd5;
         SC_D6:   r.val = 4'd6;
         SC_D7:   r.val = 4'd7;
         SC_D8:   r.val = 4'd8;
         SC_D9:   r.val = 4'd9;
         default: r.hit = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input sync, falling-edge detect, start/data/parity/stop
// FSM with odd-parity, stop-bit and inter-edge timeout checking.
module ps2_frame_rx
   import ps2_disp_pkg::*;
#(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       keyb_clk,
   input  logic       keyb_data,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]  kc_sync, kd_sync;
   logic        kc_prev;
   logic        fall, din, timeout;

   rx_state_t   state, state_n;
   logic [2:0]  bit_cnt, bit_cnt_n;
   logic [7:0]  shreg, shreg_n;
   logic        par_bit, par_n;
   logic [7:0]  code_n;
   logic        valid_n, err_n;
   logic [TW-1:0] tmo_cnt;

   // Sync flops reset to the bus idle level so reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         kc_sync <= 2'b11;
         kd_sync <= 2'b11;
         kc_prev <= 1'b1;
      end else begin
         kc_sync <= {kc_sync[0], keyb_clk};
         kd_sync <= {kd_sync[0], keyb_data};
         kc_prev <= kc_sync[1];
      end
   end

   assign fall    = kc_prev & ~kc_sync[1];
   assign din     = kd_sync[1];
   assign timeout = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYC));

   always_ff @(posedge clk) begin
      if (reset || state == IDLE || fall)
         tmo_cnt <= '0;
      else if (!timeout)
         tmo_cnt <= tmo_cnt + TW'(1);
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_n     = par_bit;
      code_n    = code;
      valid_n   = 1'b0;
      err_n     = 1'b0;
      if (fall) begin
         case (state)
            IDLE: begin
               if (!din) begin
                  state_n   = DATA;
                  bit_cnt_n = 3'd0;
               end
            end
            DATA: begin
               shreg_n   = {din, shreg[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = PARITY;
            end
            PARITY: begin
               par_n   = din;
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (din && (^{shreg, par_bit})) begin
                  valid_n = 1'b1;
                  code_n  = shreg;
               end else begin
                  err_n = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end else if (timeout) begin
         state_n = IDLE;
         err_n   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         shreg      <= 8'd0;
         par_bit    <= 1'b0;
         code       <= 8'd0;
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         par_bit    <= par_n;
         code       <= code_n;
         code_valid <= valid_n;
         frame_err  <= err_n;
      end
   end

endmodule

// File: rtl/ps2_digit_display.sv
// PS/2 keypad to N-digit multiplexed common-anode display: make/break/extended
// filtering, shift buffer with backspace and clear, registered digit scan.
module ps2_digit_display
   import ps2_disp_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            keyb_clk,
   input  logic                            keyb_data,
   input  logic                            clear,
   output logic [6:0]                      seg,
   output logic [NUM_DIGITS-1:0]           an,
   output logic                            frame_err,
   output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count
);

   localparam int CW = $clog2(NUM_DIGITS + 1);
   localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int RW = $clog2(REFRESH_DIV);

   logic [7:0] code;
   logic       code_valid;

   ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .clk        (clk),
      .reset      (reset),
      .keyb_clk   (keyb_clk),
      .keyb_data  (keyb_data),
      .code       (code),
      .code_valid (code_valid),
      .frame_err  (frame_err)
   );

   // ---- prefix filter ----
   logic       ext, brk;
   logic       is_prefix;
   logic       push_dig, do_bs, bs_ok;
   key_digit_t kd;

   assign is_prefix = (code == SC_EXT) || (code == SC_BRK);

   always_comb begin
      kd       = decode_digit(code);
      push_dig = 1'b0;
      do_bs    = 1'b0;
      if (code_valid && !is_prefix && !ext && !brk) begin
         push_dig = kd.hit;
         do_bs    = (code == SC_BKSP);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (code_valid) begin
         if (code == SC_EXT)
            ext <= 1'b1;
         else if (code == SC_BRK)
            brk <= 1'b1;
         else begin
            ext <= 1'b0;
            brk <= 1'b0;
         end
      end
   end

   // ---- digit buffer, entry 0 newest ----
   logic [NUM_DIGITS-1:0][3:0] digits, digits_n;

   assign bs_ok = do_bs && (digit_count != '0);

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_ent
      logic [3:0] up_src, dn_src;
      if (g == 0) begin : g_lo
         assign up_src = kd.val;
      end else begin : g_mid
         assign up_src = digits[g-1];
      end
      if (g == NUM_DIGITS - 1) begin : g_hi
         assign dn_src = 4'd0;
      end else begin : g_dn
         assign dn_src = digits[g+1];
      end
      assign digits_n[g] = push_dig ? up_src : (bs_ok ? dn_src : digits[g]);
   end

   // Clear only zeroes the count; stale entries are masked by the display.
   always_ff @(posedge clk) begin
      if (reset) begin
         digits      <= '0;
         digit_count <= '0;
      end else if (clear) begin
         digit_count <= '0;
      end else begin
         digits <= digits_n;
         if (push_dig && digit_count != CW'(NUM_DIGITS))
            digit_count <= digit_count + CW'(1);
         else if (bs_ok)
            digit_count <= digit_count - CW'(1);
      end
   end

   // ---- display multiplexer ----
   logic [RW-1:0] ref_cnt;
   logic [SW-1:0] slot, slot_nx;
   logic          slot_end;

   assign slot_end = (ref_cnt == RW'(REFRESH_DIV - 1));
   assign slot_nx  = (slot == SW'(NUM_DIGITS - 1)) ? '0 : slot + SW'(1);

   // seg/an are loaded for the upcoming slot so both switch on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         ref_cnt <= '0;
         slot    <= '0;
         an      <= ~NUM_DIGITS'(1);
         seg     <= SEG_BLANK;
      end else begin
         ref_cnt <= slot_end ? '0 : ref_cnt + RW'(1);
         if (slot_end) begin
            slot <= slot_nx;
            an   <= ~(NUM_DIGITS'(1) << slot_nx);
            seg  <= (int'(slot_nx) < int'(digit_count)) ? seg_rom(digits[slot_nx])
                                                        : SEG_BLANK;
         end
      end
   end

endmodule
